// File: rtl/b9_eval_arbiter_if.sv
// Request/response bundle between NREQ requesters, the shared b9 core and the arbiter.
// The arbiter side uses the slave modport; requesters/core model use master.
interface b9_eval_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ*41-1:0]   req_vec;
    logic [NREQ-1:0]      gnt;
    logic [40:0]          core_in;
    logic [20:0]          core_out;
    logic [NREQ-1:0]      rsp_valid;
    logic [20:0]          rsp_data;
    logic                 busy;

    modport slave (
        input  req,
        input  req_vec,
        input  core_out,
        output gnt,
        output core_in,
        output rsp_valid,
        output rsp_data,
        output busy
    );

    modport master (
        output req,
        output req_vec,
        output core_out,
        input  gnt,
        input  core_in,
        input  rsp_valid,
        input  rsp_data,
        input  busy
    );
endinterface

// File: rtl/b9_eval_arbiter.sv
// Shares one combinational b9 core among NREQ requesters: grant, settle WAIT cycles, capture.
// Define B9_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module b9_eval_arbiter #(
    parameter int NREQ = 4,
    parameter int WAIT = 1
) (
    input logic           clk,
    input logic           rst_n,
    b9_eval_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        SETTLE
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [IW-1:0]   win_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [40:0]     core_in_q;
    logic [20:0]     rsp_data_q;

    logic [IW-1:0]   win_d;
    logic            any_req;
    logic [40:0]     vec_slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign vec_slice[gi] = bus.req_vec[41*gi +: 41];
        end
    endgenerate

    assign any_req = |bus.req;

`ifdef B9_ARB_RR_EN
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     ptr_d;
    logic [2*NREQ-1:0] dbl_req;
    logic [NREQ-1:0]   rot_req;
    logic [IW-1:0]     off;
    logic [IW:0]       sum;

    // Rotate so the pointer position becomes bit 0, then take the lowest set bit.
    always_comb begin
        dbl_req = {bus.req, bus.req} >> ptr_q;
        rot_req = dbl_req[NREQ-1:0];
        off     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                off = IW'(i);
            end
        end
        sum = {1'b0, ptr_q} + {1'b0, off};
        if (sum >= (IW+1)'(NREQ)) begin
            sum = sum - (IW+1)'(NREQ);
        end
        win_d = sum[IW-1:0];
        ptr_d = (win_d == IW'(NREQ - 1)) ? '0 : win_d + 1'b1;
    end
`else
    always_comb begin
        win_d = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win_d = IW'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            win_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            core_in_q   <= '0;
            rsp_data_q  <= '0;
`ifdef B9_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q     <= {{(NREQ-1){1'b0}}, 1'b1} << win_d;
                        win_q     <= win_d;
                        core_in_q <= vec_slice[win_d];
                        cnt_q     <= 4'(WAIT);
                        state_q   <= SETTLE;
`ifdef B9_ARB_RR_EN
                        ptr_q     <= ptr_d;
`endif
                    end
                end
                SETTLE: begin
                    // core_in_q is frozen here, so requester activity cannot disturb the result.
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rsp_data_q  <= bus.core_out;
                        rsp_valid_q <= {{(NREQ-1){1'b0}}, 1'b1} << win_q;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.core_in   = core_in_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = (state_q == SETTLE);

endmodule

// File: tb/tb_b9_eval_arbiter.sv
// Scoreboard bench for b9_eval_arbiter: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares; two extra instances cover WAIT=0 and WAIT=15.
module tb_b9_eval_arbiter;
    localparam int W = 1;

    localparam logic [40:0] VA   = 41'h0AB_CDEF_0123;
    localparam logic [40:0] VB   = 41'h155_5555_5555;
    localparam logic [40:0] V1   = 41'h1FF_0000_FFFF;
    localparam logic [40:0] V2   = 41'h0F0_F0F0_F0F0;
    localparam logic [40:0] V3   = 41'h123_4567_89AB;
    localparam logic [40:0] V4   = 41'h0AA_0055_AA00;
    localparam logic [40:0] V5   = 41'h1BE_EF00_0001;
    localparam logic [40:0] V6   = 41'h07F_FFFF_FFFF;
    localparam logic [40:0] AV0  = 41'h0DE_ADBE_EF01;
    localparam logic [40:0] AV15 = 41'h1CA_FEBA_BE77;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   failed;

    // Stand-in reference for the b9 core: any fixed combinational 41->21 map.
    function automatic logic [20:0] b9_model(input logic [40:0] v);
        return v[20:0] ^ v[40:20] ^ {v[10:0], v[40:31]};
    endfunction

    b9_eval_arbiter_if #(.NREQ(4)) bus   ();
    b9_eval_arbiter_if #(.NREQ(4)) bus0  ();
    b9_eval_arbiter_if #(.NREQ(4)) bus15 ();

    assign bus.core_out   = b9_model(bus.core_in);
    assign bus0.core_out  = b9_model(bus0.core_in);
    assign bus15.core_out = b9_model(bus15.core_in);

    b9_eval_arbiter #(.NREQ(4), .WAIT(W))  dut     (.clk(clk), .rst_n(rst_n), .bus(bus));
    b9_eval_arbiter #(.NREQ(4), .WAIT(0))  dut_w0  (.clk(clk), .rst_n(rst_n), .bus(bus0));
    b9_eval_arbiter #(.NREQ(4), .WAIT(15)) dut_w15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [3:0]  oh;
        logic [40:0] vec;
        logic [20:0] data;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Request sampled at the edge ending cycle t: grant in t+1, response in t+2+W.
    task automatic expect_txn(input int t, input int idx, input logic [40:0] v, input bit with_rsp);
        exp_t e;
        e.cyc  = t + 1;
        e.oh   = 4'b0001 << idx;
        e.vec  = v;
        e.data = b9_model(v);
        gq.push_back(e);
        if (with_rsp) begin
            e.cyc = t + 2 + W;
            rq.push_back(e);
        end
    endtask

    task automatic set_vec(input int k, input logic [40:0] v);
        bus.req_vec[41*k +: 41] = v;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor
    exp_t        mon_e;
    logic [40:0] held_vec;
    initial held_vec = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.gnt != 4'b0000) begin
                if (gq.size() == 0) begin
                    check("unexpected_gnt", {60'd0, bus.gnt}, 64'd0);
                end else begin
                    mon_e = gq.pop_front();
                    check("gnt", {60'd0, bus.gnt}, {60'd0, mon_e.oh});
                    check("gnt_cycle", 64'(cyc), 64'(mon_e.cyc));
                    check("core_in_at_gnt", {23'd0, bus.core_in}, {23'd0, mon_e.vec});
                    check("busy_at_gnt", {63'd0, bus.busy}, 64'd1);
                    $display("[TB] cycle %0d grant %b core_in %h", cyc, bus.gnt, bus.core_in);
                    held_vec = mon_e.vec;
                end
            end else if (bus.busy) begin
                check("core_in_hold", {23'd0, bus.core_in}, {23'd0, held_vec});
            end
            if (bus.rsp_valid != 4'b0000) begin
                if (rq.size() == 0) begin
                    check("unexpected_rsp", {60'd0, bus.rsp_valid}, 64'd0);
                end else begin
                    mon_e = rq.pop_front();
                    check("rsp_valid", {60'd0, bus.rsp_valid}, {60'd0, mon_e.oh});
                    check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
                    check("rsp_data", {43'd0, bus.rsp_data}, {43'd0, mon_e.data});
                    $display("[TB] cycle %0d response %b data %h", cyc, bus.rsp_valid, bus.rsp_data);
                end
            end
        end
    end

    // Event recorders for the WAIT=0 / WAIT=15 instances
    int          g0, r0, g15, r15, b15;
    logic [20:0] d0, d15;
    initial begin
        g0 = -1; r0 = -1; g15 = -1; r15 = -1; b15 = 0; d0 = '0; d15 = '0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus0.gnt != 4'b0000 && g0 < 0)        g0 = cyc;
            if (bus0.rsp_valid != 4'b0000 && r0 < 0)  begin r0 = cyc; d0 = bus0.rsp_data; end
            if (bus15.gnt != 4'b0000 && g15 < 0)      g15 = cyc;
            if (bus15.rsp_valid != 4'b0000 && r15 < 0) begin r15 = cyc; d15 = bus15.rsp_data; end
            if (bus15.busy) b15++;
        end
    end

    int c;

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        bus.req = '0;   bus.req_vec = '0;
        bus0.req = '0;  bus0.req_vec = '0;
        bus15.req = '0; bus15.req_vec = '0;

        step(3);
        check("rst_gnt",       {60'd0, bus.gnt},       64'd0);
        check("rst_rsp_valid", {60'd0, bus.rsp_valid}, 64'd0);
        check("rst_rsp_data",  {43'd0, bus.rsp_data},  64'd0);
        check("rst_core_in",   {23'd0, bus.core_in},   64'd0);
        check("rst_busy",      {63'd0, bus.busy},      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);

        // Single request held one cycle; all three WAIT variants
        c = cyc;
        bus.req = 4'b0001; set_vec(0, 41'h1);
        bus0.req = 4'b0001;  bus0.req_vec[40:0] = AV0;
        bus15.req = 4'b0001; bus15.req_vec[40:0] = AV15;
        expect_txn(c, 0, 41'h1, 1'b1);
        step(1);
        bus.req = '0; bus0.req = '0; bus15.req = '0;
        step(20);
        check("w0_gnt_cycle",   64'(g0),  64'(c + 1));
        check("w0_rsp_cycle",   64'(r0),  64'(c + 2));
        check("w0_rsp_data",    {43'd0, d0},  {43'd0, b9_model(AV0)});
        check("w15_gnt_cycle",  64'(g15), 64'(c + 1));
        check("w15_rsp_cycle",  64'(r15), 64'(c + 17));
        check("w15_busy_count", 64'(b15), 64'd16);
        check("w15_rsp_data",   {43'd0, d15}, {43'd0, b9_model(AV15)});

        // Requesters 1 and 3 held continuously
        c = cyc;
        bus.req = 4'b1010; set_vec(1, VA); set_vec(3, VB);
`ifdef B9_ARB_RR_EN
        expect_txn(c,     1, VA, 1'b1);
        expect_txn(c + 3, 3, VB, 1'b1);
        expect_txn(c + 6, 1, VA, 1'b1);
`else
        expect_txn(c,     1, VA, 1'b1);
        expect_txn(c + 3, 1, VA, 1'b1);
        expect_txn(c + 6, 1, VA, 1'b1);
`endif
        step(8);
        bus.req = '0;
        step(4);

        // Vector and request changes during SETTLE; back-to-back grant
        c = cyc;
        bus.req = 4'b0100; set_vec(2, V1);
        expect_txn(c, 2, V1, 1'b1);
        step(1);
        bus.req = 4'b0001; set_vec(0, V3); set_vec(2, V2);
        expect_txn(c + 3, 0, V3, 1'b1);
        step(1);
        set_vec(2, V4);
        step(2);
        bus.req = '0;
        step(1);
        set_vec(0, V5);
        step(4);

        // Reset in the middle of a transaction: grant but no response
        c = cyc;
        bus.req = 4'b0001; set_vec(0, V6);
        expect_txn(c, 0, V6, 1'b0);
        step(1);
        bus.req = '0;
        step(1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_gnt",       {60'd0, bus.gnt},       64'd0);
        check("abort_rsp_valid", {60'd0, bus.rsp_valid}, 64'd0);
        check("abort_rsp_data",  {43'd0, bus.rsp_data},  64'd0);
        check("abort_core_in",   {23'd0, bus.core_in},   64'd0);
        check("abort_busy",      {63'd0, bus.busy},      64'd0);
        bus.req = 4'b1111;
        set_vec(0, VA); set_vec(1, VB); set_vec(2, V1); set_vec(3, V2);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
`ifdef B9_ARB_RR_EN
        expect_txn(c,      0, VA, 1'b1);
        expect_txn(c + 3,  1, VB, 1'b1);
        expect_txn(c + 6,  2, V1, 1'b1);
        expect_txn(c + 9,  3, V2, 1'b1);
        expect_txn(c + 12, 0, VA, 1'b1);
`else
        expect_txn(c,      0, VA, 1'b1);
        expect_txn(c + 3,  0, VA, 1'b1);
        expect_txn(c + 6,  0, VA, 1'b1);
        expect_txn(c + 9,  0, VA, 1'b1);
        expect_txn(c + 12, 0, VA, 1'b1);
`endif
        step(14);
        bus.req = '0;
        step(6);

        check("missing_gnts", 64'(gq.size()), 64'd0);
        check("missing_rsps", 64'(rq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
